// File: rtl/ex_issue_ctrl.sv
// ex_issue_ctrl: issue/handshake control between decode and execute.
// Latches one decoded operation into the ex_* registers and sequences it
// through EMPTY -> (BUSY) -> DONE. Operations whose ALUOp field equals MC_OP
// occupy execute for MC_LAT cycles; all others produce a result one cycle
// after accept. A DONE result hands over to the next stage without a bubble
// when a new operation is accepted in the same cycle.
// Optional feature: define EX_ISSUE_STALL_CNT_EN to add the stall_cnt output,
// a saturating count of cycles in which decode offered and was refused.
module ex_issue_ctrl #(
    parameter logic [3:0] MC_OP  = 4'hF,
    parameter int         MC_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_data1,
    input  logic [31:0] id_data2,
    input  logic [31:0] id_controls,
    input  logic [25:0] id_locations,

    input  logic        flush,
    input  logic        out_ready,

    output logic [31:0] ex_data1,
    output logic [31:0] ex_data2,
    output logic [31:0] ex_controls,
    output logic [25:0] ex_locations,
    output logic        ex_start,
    output logic        ex_busy,
    output logic        ex_valid
`ifdef EX_ISSUE_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    // The down-counter is 4 bits wide, so the latency must fit 2..15.
    generate
        if (MC_LAT < 2 || MC_LAT > 15) begin : g_bad_lat
            $error("ex_issue_ctrl: MC_LAT must be in 2..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Counter start value: BUSY spends MC_LAT-1 cycles, DONE follows.
    localparam logic [3:0] CNT_INIT = 4'(MC_LAT - 2);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       accept;
    logic       is_mc;

    assign is_mc = (id_controls[31:28] == MC_OP);

    // State and latency counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_EMPTY;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, handshake and status decode; flush overrides everything.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        id_ready  = 1'b0;
        accept    = 1'b0;
        ex_busy   = 1'b0;
        ex_valid  = 1'b0;

        case (state)
            S_EMPTY: begin
                id_ready = 1'b1;
            end
            S_BUSY: begin
                ex_busy = 1'b1;
            end
            S_DONE: begin
                ex_valid = 1'b1;
                id_ready = out_ready;
            end
            default: begin
                id_ready = 1'b0;
            end
        endcase

        if (flush) begin
            id_ready = 1'b0;
        end

        accept = id_valid && id_ready;

        if (flush) begin
            state_nxt = S_EMPTY;
            cnt_nxt   = 4'd0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        if (is_mc) begin
                            state_nxt = S_BUSY;
                            cnt_nxt   = CNT_INIT;
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt == 4'd0) begin
                        state_nxt = S_DONE;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        if (accept) begin
                            if (is_mc) begin
                                state_nxt = S_BUSY;
                                cnt_nxt   = CNT_INIT;
                            end else begin
                                state_nxt = S_DONE;
                            end
                        end else begin
                            state_nxt = S_EMPTY;
                        end
                    end
                end
                default: begin
                    state_nxt = S_EMPTY;
                    cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // Operand/control registers feeding execute; only an accept loads them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_data1     <= 32'd0;
            ex_data2     <= 32'd0;
            ex_controls  <= 32'd0;
            ex_locations <= 26'd0;
        end else if (accept) begin
            ex_data1     <= id_data1;
            ex_data2     <= id_data2;
            ex_controls  <= id_controls;
            ex_locations <= id_locations;
        end
    end

    // Start pulse: one cycle after each accept, back-to-back included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_start <= 1'b0;
        end else begin
            ex_start <= accept;
        end
    end

`ifdef EX_ISSUE_STALL_CNT_EN
    // Saturating count of cycles where decode offered but was refused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if (id_valid && !id_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed self-checking bench for ex_issue_ctrl (MC_OP=4'hF, MC_LAT=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. "Cycle n" means the n-th cycle after the accepting edge.
module tb_ex_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_data1;
    logic [31:0] id_data2;
    logic [31:0] id_controls;
    logic [25:0] id_locations;
    logic        flush;
    logic        out_ready;
    logic [31:0] ex_data1;
    logic [31:0] ex_data2;
    logic [31:0] ex_controls;
    logic [25:0] ex_locations;
    logic        ex_start;
    logic        ex_busy;
    logic        ex_valid;
`ifdef EX_ISSUE_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] ops [3];

    ex_issue_ctrl #(.MC_OP(4'hF), .MC_LAT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_data1     (id_data1),
        .id_data2     (id_data2),
        .id_controls  (id_controls),
        .id_locations (id_locations),
        .flush        (flush),
        .out_ready    (out_ready),
        .ex_data1     (ex_data1),
        .ex_data2     (ex_data2),
        .ex_controls  (ex_controls),
        .ex_locations (ex_locations),
        .ex_start     (ex_start),
        .ex_busy      (ex_busy),
        .ex_valid     (ex_valid)
`ifdef EX_ISSUE_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] ctrl, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [25:0] loc);
        id_valid     = 1'b1;
        id_controls  = ctrl;
        id_data1     = d1;
        id_data2     = d2;
        id_locations = loc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        id_data1 = '0; id_data2 = '0; id_controls = '0; id_locations = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_valid", ex_valid, 0);
        chk("rst_busy", ex_busy, 0);
        chk("rst_start", ex_start, 0);
        chk("rst_ready", id_ready, 1);
        chk("rst_ctrl", ex_controls, 0);
        chk("rst_loc", ex_locations, 0);
        rst_n = 1'b1;

        // Single-cycle op (ALUOp 2)
        @(posedge clk); #1;
        offer(32'h2000_0011, 32'hAAAA_0001, 32'hBBBB_0002, 26'h3E0_0123);
        @(posedge clk); #1;
        id_valid = 1'b0;
        @(negedge clk);
        chk("sc_start", ex_start, 1);
        chk("sc_valid", ex_valid, 1);
        chk("sc_busy", ex_busy, 0);
        chk("sc_ctrl", ex_controls, 32'h2000_0011);
        chk("sc_d1", ex_data1, 32'hAAAA_0001);
        chk("sc_d2", ex_data2, 32'hBBBB_0002);
        chk("sc_loc", ex_locations, 26'h3E0_0123);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sc_empty_valid", ex_valid, 0);
        chk("sc_empty_start", ex_start, 0);
        chk("sc_empty_ready", id_ready, 1);

        // Multi-cycle op: busy in cycles 1-3, valid in cycle 4
        offer(32'hF000_0005, 32'd7, 32'd9, 26'd1);
        @(posedge clk); #1;
        id_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("mc_busy_c%0d", c), ex_busy, (c <= 3) ? 1 : 0);
            chk($sformatf("mc_valid_c%0d", c), ex_valid, (c == 4) ? 1 : 0);
            chk($sformatf("mc_ready_c%0d", c), id_ready, (c == 4) ? 1 : 0);
            chk($sformatf("mc_start_c%0d", c), ex_start, (c == 1) ? 1 : 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("mc_after_valid", ex_valid, 0);

        // Three back-to-back single-cycle ops, no empty cycle
        ops[0] = 32'h1000_00A1;
        ops[1] = 32'h3000_00B2;
        ops[2] = 32'h5000_00C3;
        @(posedge clk); #1;
        offer(ops[0], 32'd1, 32'd2, 26'd3);
        for (int i = 0; i <= 3; i++) begin
            @(posedge clk); #1;
            if (i < 2) offer(ops[i+1], 32'd1, 32'd2, 26'd3);
            else id_valid = 1'b0;
            @(negedge clk);
            if (i < 3) begin
                chk($sformatf("b2b_valid_%0d", i), ex_valid, 1);
                chk($sformatf("b2b_start_%0d", i), ex_start, 1);
                chk($sformatf("b2b_ctrl_%0d", i), ex_controls, ops[i]);
            end else begin
                chk("b2b_end_valid", ex_valid, 0);
                chk("b2b_end_start", ex_start, 0);
            end
        end

        // DONE held for 5 cycles with out_ready=0 while decode keeps offering
        @(posedge clk); #1;
        offer(32'h4000_0D0D, 32'hD1D1_D1D1, 32'hD2D2_D2D2, 26'h0D0D);
        @(posedge clk); #1;
        offer(32'h6000_0E0E, 32'hE1E1_E1E1, 32'hE2E2_E2E2, 26'h0E0E);
        out_ready = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold_valid_c%0d", c), ex_valid, 1);
            chk($sformatf("hold_ready_c%0d", c), id_ready, 0);
            chk($sformatf("hold_ctrl_c%0d", c), ex_controls, 32'h4000_0D0D);
            chk($sformatf("hold_d1_c%0d", c), ex_data1, 32'hD1D1_D1D1);
            chk($sformatf("hold_loc_c%0d", c), ex_locations, 26'h0D0D);
            if (c > 1) chk($sformatf("hold_start_c%0d", c), ex_start, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_ready", id_ready, 1);
        chk("hold_release_ctrl", ex_controls, 32'h4000_0D0D);
`ifdef EX_ISSUE_STALL_CNT_EN
        chk("stall_cnt_5", stall_cnt, 5);
`endif
        @(posedge clk); #1;
        id_valid = 1'b0;
        @(negedge clk);
        chk("held_offer_ctrl", ex_controls, 32'h6000_0E0E);
        chk("held_offer_d2", ex_data2, 32'hE2E2_E2E2);
        chk("held_offer_start", ex_start, 1);
        chk("held_offer_valid", ex_valid, 1);
        @(posedge clk); #1;

        // Flush in the 2nd BUSY cycle
        offer(32'hF000_0F0F, 32'd11, 32'd12, 26'd13);
        @(posedge clk); #1;
        offer(32'h2000_0999, 32'd99, 32'd98, 26'd97);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("fl_busy_c2", ex_busy, 1);
        chk("fl_ready_c2", id_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        id_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("fl_novalid_%0d", c), ex_valid, 0);
            chk($sformatf("fl_nobusy_%0d", c), ex_busy, 0);
            @(posedge clk); #1;
        end
        chk("fl_keep_ctrl", ex_controls, 32'hF000_0F0F);
        chk("fl_ready_after", id_ready, 1);

        // Flush in EMPTY only blocks the offer for that cycle
        offer(32'h7000_0777, 32'd70, 32'd71, 26'd72);
        flush = 1'b1;
        @(negedge clk);
        chk("fe_ready", id_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("fe_no_start", ex_start, 0);
        chk("fe_no_valid", ex_valid, 0);
        chk("fe_ready_back", id_ready, 1);
        @(posedge clk); #1;
        id_valid = 1'b0;
        @(negedge clk);
        chk("fe_accept_valid", ex_valid, 1);
        chk("fe_accept_ctrl", ex_controls, 32'h7000_0777);
        @(posedge clk); #1;

        // Asynchronous reset mid-BUSY
        offer(32'hF000_0ABC, 32'h1234_5678, 32'h9ABC_DEF0, 26'h155_5555);
        @(posedge clk); #1;
        id_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", ex_busy, 0);
        chk("ar_valid", ex_valid, 0);
        chk("ar_start", ex_start, 0);
        chk("ar_ready", id_ready, 1);
        chk("ar_ctrl", ex_controls, 0);
        chk("ar_d1", ex_data1, 0);
`ifdef EX_ISSUE_STALL_CNT_EN
        chk("ar_stall", stall_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ar_post_busy", ex_busy, 0);
        offer(32'h2000_0321, 32'd5, 32'd6, 26'd8);
        @(posedge clk); #1;
        id_valid = 1'b0;
        @(negedge clk);
        chk("ar_post_valid", ex_valid, 1);
        chk("ar_post_ctrl", ex_controls, 32'h2000_0321);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
